two_word_line_eb_source: RTL
============================

# two_word_line_eb_source

Bit-serial model of one Bendix G-15 two-word short line (ID, MQ or PN class): a 58-bit recirculating store that is the early-bus source for that line and the late-bus destination for writes. It tracks bit and word position from the sign-time pulse, gates its output bit onto its early-bus term, and buffers the even-word sign. The inverting gate consumes this sign when transferring two-word lines.

## Interface
Parameters:
- WORD_BITS, 29, bits per word (bit 0 is sign time)
- LINE_BITS, 58, total line length (2 × WORD_BITS; other values unsupported)

Ports:
- CLOCK  in  1  bit-time clock; one bit per rising edge
- rst_n  in  1  reset, synchronous, active-low
- TS  in  1  sign-bit time; high for exactly one CLOCK at bit 0 of every word
- SRC_SEL  in  1  source decode selects this line for reading
- DST_SEL  in  1  destination decode selects this line for writing
- LB  in  1  late-bus data bit written when DST_SEL
- SIGN_FOLD  in  1  substitute the buffered even sign at odd-word sign time
- PG_CLEAR  in  1  clear line contents
- EB_OUT  out  1  early-bus term for this line
- LINE_BIT  out  1  ungated recirculating bit (line[0])
- WORD_ODD  out  1  current word is odd
- BIT_NUM  out  5  current bit position, 0..28
- SIGN_EVEN  out  1  sign of the most recent even word
- SYNCED  out  1  position tracking locked
- SYNC_ERR  out  1  sticky: TS arrived at the wrong bit position

## Operation
- Storage: 58-bit shift register `line`, LSB first. Every CLOCK: line <= {next_in, line[57:1]}.
- next_in priority: PG_CLEAR → 0; else DST_SEL & SYNCED → LB; else line[0] (recirculate).
- FSM states:
  - UNSYNC (reset state): writes inhibited and EB_OUT = 0. The first TS loads BIT_NUM=0, WORD_ODD=0 and moves to SYNC in the same cycle.
  - SYNC: BIT_NUM increments each CLOCK and wraps 28→0. WORD_ODD toggles on each wrap.
- TS check while in SYNC:
  - TS with BIT_NUM ≠ 28 in the preceding cycle sets SYNC_ERR.
  - It then realigns BIT_NUM to 0 and WORD_ODD to 0, and the FSM stays in SYNC.
  - A missing TS at the wrap is not an error; the counter free-runs.
- SYNC_ERR clears only on reset.
- SIGN_EVEN: captures line[0] at TS when WORD_ODD=0 and holds it until the next even-word TS. Capture takes the pre-write value.
- EB_OUT = SYNCED & SRC_SEL & (SIGN_FOLD & TS & WORD_ODD ? SIGN_EVEN : line[0]).
- Simultaneous read and write: EB_OUT carries the old bit and the line takes LB. Self-transfer (SRC_SEL & DST_SEL with LB=EB_OUT) leaves the contents unchanged.

## Timing
- Reset (rst_n low at an edge) produces:
  - line = 0, UNSYNC, BIT_NUM = 0, WORD_ODD = 0
  - SIGN_EVEN = 0, SYNC_ERR = 0
  - all outputs 0
- EB_OUT and LINE_BIT are combinational from registered state plus SRC_SEL, SIGN_FOLD and TS; there are no register stages.
- A bit written at cycle n reappears on LINE_BIT at cycle n+58.
- SYNCED is high from the cycle after the first TS. WORD_ODD and BIT_NUM are valid in that same cycle.
- PG_CLEAR must be held ≥ 58 cycles to zero the whole line. A partial clear zeroes exactly the bits shifted during assertion.
- Reset mid-transfer: all content is lost and the line returns to UNSYNC; no write is completed.

## Structure
- Shared package g15_pkg holds:
  - WORD_BITS
  - LINE_BITS
  - the sync FSM enum (UNSYNC, SYNC)
  - the bit-number type logic [4:0]
- Sub-module word_timer holds BIT_NUM, WORD_ODD, the FSM and SYNC_ERR. It is reused by other two-word lines.
- The top level holds the shift register, SIGN_EVEN and the EB gating.

## Test plan
- Reset then TS every 29 cycles: SYNCED rises one cycle after the first TS, WORD_ODD toggles 0,1,0, and BIT_NUM goes 0..28.
- Write 58-bit pattern 0x2AAAAAAAAAAAAAA via DST_SEL/LB from the even TS, then SRC_SEL: EB_OUT replays the identical pattern from the next even TS, LSB first, repeatedly.
- Even-word sign bit = 1, odd-word sign = 0, SIGN_FOLD=1: EB_OUT = 1 at odd-word TS and SIGN_EVEN = 1. With SIGN_FOLD=0, EB_OUT = 0 at that TS.
- TS injected at BIT_NUM=10: SYNC_ERR = 1 (sticky), BIT_NUM → 0, WORD_ODD → 0 next cycle, and line content is unchanged.
- PG_CLEAR for 58 cycles after loading all-ones: LINE_BIT = 0 for the following 58 cycles. A 10-cycle clear zeroes exactly 10 bits.
- rst_n low mid-write with SRC_SEL=1: next cycle EB_OUT = 0, SYNCED = 0, line all zero, and DST_SEL is ignored until the next TS.

Source files
------------

// File: rtl/g15_pkg.sv
// Shared constants and types for G-15 serial line models.
package g15_pkg;

  localparam int WORD_BITS = 29;
  localparam int LINE_BITS = 58;

  // Position tracking is either waiting for the first sign pulse or locked to it.
  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } sync_state_t;

  typedef logic [4:0] bit_num_t;

endpackage

// File: rtl/word_timer.sv
// Bit/word position tracker locked to the sign-time pulse, with a sticky
// misalignment flag. Shared by every two-word line.
module word_timer
  import g15_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_ts,
  output logic     o_synced,
  output logic     o_word_odd,
  output bit_num_t o_bit_num,
  output logic     o_sync_err,
  output logic     o_new_word_odd
);

  localparam bit_num_t LAST_BIT = bit_num_t'(WORD_BITS - 1);

  sync_state_t r_state;
  bit_num_t    r_bit_num;
  logic        r_word_odd;
  logic        r_sync_err;
  logic        w_at_wrap;

  // The registered count lags the bit time by one: a correctly placed TS
  // arrives while the count still shows the last bit of the previous word.
  assign w_at_wrap = (r_bit_num == LAST_BIT);

  // Parity of the word whose sign time is this cycle; a misplaced TS starts
  // an even word, and so does the very first TS.
  assign o_new_word_odd = (r_state == SYNC) & w_at_wrap & ~r_word_odd;

  // Sync FSM, bit/word counters and sticky error flag.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge state.
    if (!i_rst_n) begin
      r_state    <= UNSYNC;
      r_bit_num  <= '0;
      r_word_odd <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      case (r_state)
        UNSYNC: begin
          if (i_ts) begin
            r_state    <= SYNC;
            r_bit_num  <= '0;
            r_word_odd <= 1'b0;
          end
        end
        SYNC: begin
          if (i_ts && !w_at_wrap) begin
            r_sync_err <= 1'b1;
            r_bit_num  <= '0;
            r_word_odd <= 1'b0;
          end else if (w_at_wrap) begin
            r_bit_num  <= '0;
            r_word_odd <= ~r_word_odd;
          end else begin
            r_bit_num  <= bit_num_t'(r_bit_num + 5'd1);
          end
        end
        default: r_state <= UNSYNC;
      endcase
    end
  end

  assign o_synced   = (r_state == SYNC);
  assign o_word_odd = r_word_odd;
  assign o_bit_num  = r_bit_num;
  assign o_sync_err = r_sync_err;

endmodule

// File: rtl/two_word_line_eb_source.sv
// One G-15 two-word short line: 58-bit recirculating store, late-bus write
// port, early-bus read gating and even-word sign buffer.
module two_word_line_eb_source #(
  parameter int WORD_BITS = g15_pkg::WORD_BITS,
  parameter int LINE_BITS = 2 * WORD_BITS
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       TS,
  input  logic       SRC_SEL,
  input  logic       DST_SEL,
  input  logic       LB,
  input  logic       SIGN_FOLD,
  input  logic       PG_CLEAR,
  output logic       EB_OUT,
  output logic       LINE_BIT,
  output logic       WORD_ODD,
  output logic [4:0] BIT_NUM,
  output logic       SIGN_EVEN,
  output logic       SYNCED,
  output logic       SYNC_ERR
);

  logic [LINE_BITS-1:0] r_line;
  logic                 r_sign_even;
  logic                 w_next_in;
  logic                 w_synced;
  logic                 w_word_odd;
  logic                 w_sync_err;
  logic                 w_new_word_odd;
  g15_pkg::bit_num_t    w_bit_num;

  word_timer u_word_timer (
    .i_clk          (CLOCK),
    .i_rst_n        (rst_n),
    .i_ts           (TS),
    .o_synced       (w_synced),
    .o_word_odd     (w_word_odd),
    .o_bit_num      (w_bit_num),
    .o_sync_err     (w_sync_err),
    .o_new_word_odd (w_new_word_odd)
  );

  // Bit entering the top of the line: clear wins, then a synced write, else recirculate.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_in unassigned (no latch).
    w_next_in = r_line[0];
    if (PG_CLEAR) begin
      w_next_in = 1'b0;
    end else if (DST_SEL && w_synced) begin
      w_next_in = LB;
    end
  end

  // Shift the line one bit toward the output each bit time.
  always_ff @(posedge CLOCK) begin
    // NOTE: the store itself is reset because losing content on reset is part of the line's behaviour.
    if (!rst_n) begin
      r_line <= '0;
    end else begin
      r_line <= {w_next_in, r_line[LINE_BITS-1:1]};
    end
  end

  // Buffer the sign of each even word, taken before any write lands.
  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      r_sign_even <= 1'b0;
    end else if (TS && !w_new_word_odd) begin
      r_sign_even <= r_line[0];
    end
  end

  // Early-bus term: old line bit, or the buffered even sign folded into odd sign time.
  assign EB_OUT = w_synced & SRC_SEL &
                  ((SIGN_FOLD & TS & w_new_word_odd) ? r_sign_even : r_line[0]);

  assign LINE_BIT  = r_line[0];
  assign WORD_ODD  = w_word_odd;
  assign BIT_NUM   = w_bit_num;
  assign SIGN_EVEN = r_sign_even;
  assign SYNCED    = w_synced;
  assign SYNC_ERR  = w_sync_err;

endmodule
